pipelined_add_tree: RTL and testbench

- Parametrised successor to the fixed three-operand pipelined adder.
- Sums NUM_INPUTS unsigned WIDTH-bit operands through a registered binary adder tree, one register level per tree level.
- Adds a valid/ready handshake with full backpressure and a synchronous reset.
- Used wherever a multi-operand accumulation must be pipelined to meet timing in the XLS-generated datapath.

---
 rtl/pipelined_add_tree.sv | 118 +++++++++++
 tb/tb_pipelined_add_tree.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_add_tree.sv
// Registered binary adder tree summing NUM_INPUTS unsigned WIDTH-bit operands with valid/ready flow control.
// Define ADD_TREE_OVF_EN to add the out_ovf port and the pipelined overflow tracking behind it.
module pipelined_add_tree #(
  parameter int NUM_INPUTS = 3,
  parameter int WIDTH      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data
`ifdef ADD_TREE_OVF_EN
  ,
  output logic                        out_ovf
`endif
);

  localparam int LEVELS = $clog2(NUM_INPUTS);

  function automatic int node_count(input int lvl);
    int c;
    c = NUM_INPUTS;
    for (int k = 0; k < lvl; k++) c = (c + 1) / 2;
    return c;
  endfunction

  logic             advance;
  logic [WIDTH-1:0] data_p [0:LEVELS][0:NUM_INPUTS-1];
  logic             vld_p  [0:LEVELS];
`ifdef ADD_TREE_OVF_EN
  logic             ovf_p  [0:LEVELS][0:NUM_INPUTS-1];
`endif

  // The whole pipe moves as one unit; the final stage only blocks when it holds real data.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l <= LEVELS; l++) vld_p[l] <= 1'b0;
    end else if (advance) begin
      vld_p[0] <= in_valid;
      for (int l = 1; l <= LEVELS; l++) vld_p[l] <= vld_p[l-1];
    end
  end

  // Stage 0: raw operand registers
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_p0
    always_ff @(posedge clk) begin
      if (rst) begin
        data_p[0][i] <= '0;
`ifdef ADD_TREE_OVF_EN
        ovf_p[0][i]  <= 1'b0;
`endif
      end else if (advance) begin
        data_p[0][i] <= in_data[i*WIDTH +: WIDTH];
`ifdef ADD_TREE_OVF_EN
        ovf_p[0][i]  <= 1'b0;
`endif
      end
    end
  end

  // Stages 1..LEVELS: node i adds elements 2i and 2i+1 of the previous level
  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int PREV = node_count(l - 1);
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_node
      logic [WIDTH-1:0] nxt;
`ifdef ADD_TREE_OVF_EN
      logic             nxt_ovf;
`endif
      if (2 * i + 1 < PREV) begin : g_add
`ifdef ADD_TREE_OVF_EN
        logic [WIDTH:0] full;
        assign full    = {1'b0, data_p[l-1][2*i]} + {1'b0, data_p[l-1][2*i+1]};
        assign nxt     = full[WIDTH-1:0];
        assign nxt_ovf = ovf_p[l-1][2*i] | ovf_p[l-1][2*i+1] | full[WIDTH];
`else
        assign nxt = data_p[l-1][2*i] + data_p[l-1][2*i+1];
`endif
      end else if (2 * i < PREV) begin : g_pass
        assign nxt     = data_p[l-1][2*i];
`ifdef ADD_TREE_OVF_EN
        assign nxt_ovf = ovf_p[l-1][2*i];
`endif
      end else begin : g_none
        assign nxt     = '0;
`ifdef ADD_TREE_OVF_EN
        assign nxt_ovf = 1'b0;
`endif
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          data_p[l][i] <= '0;
`ifdef ADD_TREE_OVF_EN
          ovf_p[l][i]  <= 1'b0;
`endif
        end else if (advance) begin
          data_p[l][i] <= nxt;
`ifdef ADD_TREE_OVF_EN
          ovf_p[l][i]  <= nxt_ovf;
`endif
        end
      end
    end
  end

  assign out_valid = vld_p[LEVELS];
  assign out_data  = data_p[LEVELS][0];
`ifdef ADD_TREE_OVF_EN
  assign out_ovf   = ovf_p[LEVELS][0];
`endif

endmodule

// File: tb/tb_pipelined_add_tree.sv
// Bench for pipelined_add_tree: a default-size instance under handshake/backpressure/reset tests and
// four further sizes (5x8, 2x16, 4x16, 16x10) run with out_ready=1 against cycle-exact expected sums.
module tb_pipelined_add_tree;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  logic        in_valid0, in_ready0, out_valid0, out_ready0;
  logic [95:0] in_data0;
  logic [31:0] out_data0;
  logic [33:0] cur0;
  logic [33:0] q0[$];
`ifdef ADD_TREE_OVF_EN
  logic        out_ovf0;
  logic [3:0]  sovf;
`endif

  pipelined_add_tree dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0)
`ifdef ADD_TREE_OVF_EN
    , .out_ovf(out_ovf0)
`endif
  );

  logic         svalid, sready;
  logic [3:0]   sin_ready, sout_valid;
  logic [39:0]  sd5;
  logic [7:0]   so5;
  logic [31:0]  sd2;
  logic [15:0]  so2;
  logic [63:0]  sd4;
  logic [15:0]  so4;
  logic [159:0] sd16;
  logic [9:0]   so16;

  pipelined_add_tree #(.NUM_INPUTS(5), .WIDTH(8)) dut5 (
    .clk(clk), .rst(rst), .in_valid(svalid), .in_ready(sin_ready[0]), .in_data(sd5),
    .out_valid(sout_valid[0]), .out_ready(sready), .out_data(so5)
`ifdef ADD_TREE_OVF_EN
    , .out_ovf(sovf[0])
`endif
  );
  pipelined_add_tree #(.NUM_INPUTS(2), .WIDTH(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(svalid), .in_ready(sin_ready[1]), .in_data(sd2),
    .out_valid(sout_valid[1]), .out_ready(sready), .out_data(so2)
`ifdef ADD_TREE_OVF_EN
    , .out_ovf(sovf[1])
`endif
  );
  pipelined_add_tree #(.NUM_INPUTS(4), .WIDTH(16)) dut4 (
    .clk(clk), .rst(rst), .in_valid(svalid), .in_ready(sin_ready[2]), .in_data(sd4),
    .out_valid(sout_valid[2]), .out_ready(sready), .out_data(so4)
`ifdef ADD_TREE_OVF_EN
    , .out_ovf(sovf[2])
`endif
  );
  pipelined_add_tree #(.NUM_INPUTS(16), .WIDTH(10)) dut16 (
    .clk(clk), .rst(rst), .in_valid(svalid), .in_ready(sin_ready[3]), .in_data(sd16),
    .out_valid(sout_valid[3]), .out_ready(sready), .out_data(so16)
`ifdef ADD_TREE_OVF_EN
    , .out_ovf(sovf[3])
`endif
  );

  int              sn[4] = '{5, 2, 4, 16};
  int              sw[4] = '{8, 16, 16, 10};
  int              sl[4] = '{4, 2, 3, 5};
  longint unsigned scur[4];
  logic            socur[4];
  logic            ev[4][0:511];
  longint unsigned ed[4][0:511];
  logic            eo[4][0:511];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned sout(input int j);
    case (j)
      0:       return 64'(so5);
      1:       return 64'(so2);
      2:       return 64'(so4);
      default: return 64'(so16);
    endcase
  endfunction

  // Operand set for an n x w instance: fixed>=0 gives every operand that value, else random.
  task automatic gen(input int n, input int w, input int fixed, output logic [1023:0] p,
                     output longint unsigned s, output logic ovf);
    longint unsigned m, v, full;
    m = (64'd1 << w) - 1;
    p = '0;
    full = 0;
    for (int k = 0; k < n; k++) begin
      v = (fixed >= 0) ? (longint'(fixed) & m) : (longint'($urandom) & m);
      for (int b = 0; b < w; b++) p[k*w+b] = v[b];
      full += v;
    end
    s   = full & m;
    ovf = (full > m);
  endtask

  task automatic drive_sweep(input logic v, input int fixed);
    logic [1023:0] p;
    longint unsigned s;
    logic o;
    svalid = v;
    for (int j = 0; j < 4; j++) begin
      gen(sn[j], sw[j], fixed, p, s, o);
      scur[j]  = s;
      socur[j] = o;
      case (j)
        0:       sd5  = p[39:0];
        1:       sd2  = p[31:0];
        2:       sd4  = p[63:0];
        default: sd16 = p[159:0];
      endcase
    end
  endtask

  task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    in_valid0 = v;
    in_data0  = {c, b, a};
    cur0      = {2'b00, a} + {2'b00, b} + {2'b00, c};
  endtask

  // One clock: score transfers seen before the edge, then check outputs just after it.
  task automatic step();
    logic        stall;
    logic [31:0] hold;
    logic [33:0] e;
    #1;
    stall = 1'b0;
    hold  = out_data0;
    if (!rst) begin
      if (in_valid0 && in_ready0) q0.push_back(cur0);
      if (out_valid0 && out_ready0) begin
        if (q0.size() == 0) chk("dut0_extra_output", 64'(out_valid0), 64'd0);
        else begin
          e = q0.pop_front();
          chk("dut0_sum", 64'(out_data0), 64'(e[31:0]));
`ifdef ADD_TREE_OVF_EN
          chk("dut0_ovf", 64'(out_ovf0), 64'(|e[33:32]));
`endif
        end
      end
      stall = out_valid0 && !out_ready0;
      if (stall) chk("stall_in_ready", 64'(in_ready0), 64'd0);
      if (svalid)
        for (int j = 0; j < 4; j++) begin
          ev[j][cyc+sl[j]] = 1'b1;
          ed[j][cyc+sl[j]] = scur[j];
          eo[j][cyc+sl[j]] = socur[j];
        end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rst) begin
      q0.delete();
      for (int j = 0; j < 4; j++)
        for (int t = cyc; t < cyc + 8; t++) ev[j][t] = 1'b0;
      chk("rst_out_valid", 64'(out_valid0), 64'd0);
      chk("rst_out_data", 64'(out_data0), 64'd0);
      chk("rst_in_ready", 64'(in_ready0), 64'd1);
`ifdef ADD_TREE_OVF_EN
      chk("rst_out_ovf", 64'(out_ovf0), 64'd0);
`endif
    end else if (stall) begin
      chk("stall_out_valid", 64'(out_valid0), 64'd1);
      chk("stall_out_data", 64'(out_data0), 64'(hold));
    end
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("sweep%0d_in_ready", j), 64'(sin_ready[j]), 64'd1);
      chk($sformatf("sweep%0d_valid_c%0d", j, cyc), 64'(sout_valid[j]), 64'(ev[j][cyc]));
      if (ev[j][cyc]) begin
        chk($sformatf("sweep%0d_sum_c%0d", j, cyc), sout(j), ed[j][cyc]);
`ifdef ADD_TREE_OVF_EN
        chk($sformatf("sweep%0d_ovf_c%0d", j, cyc), 64'(sovf[j]), 64'(eo[j][cyc]));
`endif
      end
    end
  endtask

  initial begin
    for (int j = 0; j < 4; j++)
      for (int t = 0; t < 512; t++) begin
        ev[j][t] = 1'b0;
        ed[j][t] = 0;
        eo[j][t] = 1'b0;
      end
    rst = 1'b1;
    out_ready0 = 1'b1;
    sready = 1'b1;
    drive0(1'b0, 32'd0, 32'd0, 32'd0);
    drive_sweep(1'b0, 0);
    step();
    step();
    rst = 1'b0;

    // Single set {1,2,3}: visible exactly three cycles after it is presented
    drive0(1'b1, 32'd1, 32'd2, 32'd3);
    step();
    drive0(1'b0, 32'd0, 32'd0, 32'd0);
    chk("lat_c1_valid", 64'(out_valid0), 64'd0);
    step();
    chk("lat_c2_valid", 64'(out_valid0), 64'd0);
    step();
    chk("lat_c3_valid", 64'(out_valid0), 64'd1);
    chk("lat_c3_data", 64'(out_data0), 64'd6);
    step();
    chk("lat_c4_valid", 64'(out_valid0), 64'd0);

    // Modular wrap and overflow boundaries
    drive0(1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0);
    step();
    drive0(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd1);
    step();
    drive0(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    drive0(1'b0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) step();

    // Backpressure: stall four cycles with a valid output and new offers pending
    for (int i = 0; i < 3; i++) begin
      drive0(1'b1, $urandom, $urandom, $urandom);
      step();
    end
    chk("bp_precondition_valid", 64'(out_valid0), 64'd1);
    out_ready0 = 1'b0;
    drive0(1'b1, $urandom, $urandom, $urandom);
    for (int i = 0; i < 4; i++) step();
    out_ready0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive0(1'b1, $urandom, $urandom, $urandom);
      step();
    end
    drive0(1'b0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 8; i++) step();
    chk("bp_all_drained", 64'(q0.size()), 64'd0);

    // Reset with three sets in flight; a new set follows immediately
    for (int i = 0; i < 3; i++) begin
      drive0(1'b1, $urandom, $urandom, $urandom);
      step();
    end
    rst = 1'b1;
    drive0(1'b1, $urandom, $urandom, $urandom);
    step();
    rst = 1'b0;
    drive0(1'b1, 32'd10, 32'd20, 32'd30);
    step();
    chk("post_rst_accepted", 64'(q0.size()), 64'd1);
    drive0(1'b0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 6; i++) step();
    chk("post_rst_drained", 64'(q0.size()), 64'd0);

    // Back-to-back sets {k,..,k}, k=0..9, on every sized instance
    for (int k = 0; k < 10; k++) begin
      drive_sweep(1'b1, k);
      step();
    end
    drive_sweep(1'b0, 0);
    for (int i = 0; i < 7; i++) step();

    // Random operands with random bubbles
    for (int i = 0; i < 40; i++) begin
      drive_sweep(($urandom_range(0, 3) != 0), -1);
      drive0(($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom);
      step();
    end
    drive_sweep(1'b0, 0);
    drive0(1'b0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 7; i++) step();
    chk("final_drained", 64'(q0.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
